eq_sweep_ctrl: RTL and testbench

- Sequencer that sweeps every (tx_setting, rx_setting) pair of the emulated link.
- For each pair it:
  - flushes the datapath,
  - runs emulated time through a settle window, then a measure window,
  - counts bit errors reported by the checker,
  - records the best pair.
- Drives the clkgate enable and the datapath reset.
- Replaces the fixed `TX_SETTING/`RX_SETTING constants at the top level.

---
 rtl/eq_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_eq_sweep_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_sweep_ctrl.sv
// eq_sweep_ctrl: sweeps every (tx_setting, rx_setting) pair of the emulated
// link. For each pair it flushes the datapath, lets emulated time run through a
// settle window and then a measure window, counts checker bit errors, and keeps
// the pair with the lowest error count.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | waiting for start; datapath gated and held in reset
// S_FLUSH   | datapath clocked but held in reset for FLUSH_CYCLES cycles
// S_SETTLE  | datapath running; errors ignored until SETTLE_TIME elapses
// S_MEASURE | datapath running; errors counted until MEASURE_TIME elapses
// S_EVAL    | compare this pair's count against the best so far
// S_NEXT    | step rx (inner) / tx (outer) or finish the sweep
// S_DONE    | sweep complete; results held until start or abort

module eq_sweep_ctrl #(
    parameter int TIME_WIDTH       = 32,
    parameter int TX_SETTING_WIDTH = 4,
    parameter int RX_SETTING_WIDTH = 4,
    parameter int TX_MAX           = 3,
    parameter int RX_MAX           = 3,
    parameter int FLUSH_CYCLES     = 4,
    parameter int SETTLE_TIME      = 1000,
    parameter int MEASURE_TIME     = 10000,
    parameter int ERR_WIDTH        = 16
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [TIME_WIDTH-1:0]       time_curr,
    input  logic                        err_valid,
    input  logic                        err,
    output logic [TX_SETTING_WIDTH-1:0] tx_setting,
    output logic [RX_SETTING_WIDTH-1:0] rx_setting,
    output logic                        clk_en,
    output logic                        emu_rst_n,
    output logic                        busy,
    output logic                        done,
    output logic [ERR_WIDTH-1:0]        err_count,
    output logic [TX_SETTING_WIDTH-1:0] best_tx,
    output logic [RX_SETTING_WIDTH-1:0] best_rx,
    output logic [ERR_WIDTH-1:0]        best_err
);

    localparam int FC_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [FC_W-1:0]             FC_LOAD   = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [TIME_WIDTH-1:0]       SETTLE_T  = TIME_WIDTH'(SETTLE_TIME);
    localparam logic [TIME_WIDTH-1:0]       MEASURE_T = TIME_WIDTH'(MEASURE_TIME);
    localparam logic [TX_SETTING_WIDTH-1:0] TX_LAST   = TX_SETTING_WIDTH'(TX_MAX);
    localparam logic [RX_SETTING_WIDTH-1:0] RX_LAST   = RX_SETTING_WIDTH'(RX_MAX);
    localparam logic [ERR_WIDTH-1:0]        ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [FC_W-1:0]             flush_cnt, flush_cnt_nxt;
    logic [TIME_WIDTH-1:0]       t_mark, t_mark_nxt;
    logic                        entry;
    logic                        entry_nxt;
    logic [TIME_WIDTH-1:0]       elapsed;
    logic                        settle_done;
    logic                        measure_done;

    logic [TX_SETTING_WIDTH-1:0] tx_setting_nxt;
    logic [RX_SETTING_WIDTH-1:0] rx_setting_nxt;
    logic                        clk_en_nxt;
    logic                        emu_rst_n_nxt;
    logic                        busy_nxt;
    logic                        done_nxt;
    logic [ERR_WIDTH-1:0]        err_count_nxt;
    logic [TX_SETTING_WIDTH-1:0] best_tx_nxt;
    logic [RX_SETTING_WIDTH-1:0] best_rx_nxt;
    logic [ERR_WIDTH-1:0]        best_err_nxt;

    // Modular difference so a time_curr wrap through zero still measures correctly.
    assign elapsed = time_curr - t_mark;

    // On the entry cycle t_mark is stale, so only a zero-length window may exit.
    assign settle_done  = entry ? (SETTLE_T == '0)  : (elapsed >= SETTLE_T);
    assign measure_done = entry ? (MEASURE_T == '0) : (elapsed >= MEASURE_T);

    // State register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        t_mark_nxt     = t_mark;
        tx_setting_nxt = tx_setting;
        rx_setting_nxt = rx_setting;
        err_count_nxt  = err_count;
        best_tx_nxt    = best_tx;
        best_rx_nxt    = best_rx;
        best_err_nxt   = best_err;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt      = S_FLUSH;
                    flush_cnt_nxt  = FC_LOAD;
                    tx_setting_nxt = '0;
                    rx_setting_nxt = '0;
                    best_err_nxt   = ERR_MAX;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = S_SETTLE;
                end else begin
                    flush_cnt_nxt = flush_cnt - FC_W'(1);
                end
            end
            S_SETTLE: begin
                if (entry) begin
                    t_mark_nxt = time_curr;
                end
                if (settle_done) begin
                    state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (entry) begin
                    t_mark_nxt    = time_curr;
                    err_count_nxt = '0;
                end else if (err_valid && err && (err_count != ERR_MAX)) begin
                    err_count_nxt = err_count + ERR_WIDTH'(1);
                end
                if (measure_done) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                // Strict compare: on a tie the earlier pair is kept.
                if (err_count < best_err) begin
                    best_tx_nxt  = tx_setting;
                    best_rx_nxt  = rx_setting;
                    best_err_nxt = err_count;
                end
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (rx_setting < RX_LAST) begin
                    rx_setting_nxt = rx_setting + RX_SETTING_WIDTH'(1);
                    flush_cnt_nxt  = FC_LOAD;
                    state_nxt      = S_FLUSH;
                end else if (tx_setting < TX_LAST) begin
                    rx_setting_nxt = '0;
                    tx_setting_nxt = tx_setting + TX_SETTING_WIDTH'(1);
                    flush_cnt_nxt  = FC_LOAD;
                    state_nxt      = S_FLUSH;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort beats everything, including a simultaneous start, and leaves
        // the results and settings exactly as they were.
        if (abort) begin
            state_nxt      = S_IDLE;
            flush_cnt_nxt  = flush_cnt;
            t_mark_nxt     = t_mark;
            tx_setting_nxt = tx_setting;
            rx_setting_nxt = rx_setting;
            err_count_nxt  = err_count;
            best_tx_nxt    = best_tx;
            best_rx_nxt    = best_rx;
            best_err_nxt   = best_err;
        end

        entry_nxt     = (state_nxt != state);
        clk_en_nxt    = (state_nxt == S_FLUSH) || (state_nxt == S_SETTLE) ||
                        (state_nxt == S_MEASURE);
        emu_rst_n_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE) ||
                        (state_nxt == S_EVAL)   || (state_nxt == S_NEXT);
        busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt      = (state_nxt == S_DONE);
    end

    // Datapath and output registers; outputs reflect the state they belong to.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt  <= '0;
            t_mark     <= '0;
            entry      <= 1'b0;
            tx_setting <= '0;
            rx_setting <= '0;
            clk_en     <= 1'b0;
            emu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            best_tx    <= '0;
            best_rx    <= '0;
            best_err   <= ERR_MAX;
        end else begin
            flush_cnt  <= flush_cnt_nxt;
            t_mark     <= t_mark_nxt;
            entry      <= entry_nxt;
            tx_setting <= tx_setting_nxt;
            rx_setting <= rx_setting_nxt;
            clk_en     <= clk_en_nxt;
            emu_rst_n  <= emu_rst_n_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err_count  <= err_count_nxt;
            best_tx    <= best_tx_nxt;
            best_rx    <= best_rx_nxt;
            best_err   <= best_err_nxt;
        end
    end

endmodule

// File: tb/tb_eq_sweep_ctrl.sv
// Bench for eq_sweep_ctrl: drives full sweeps with a fixed time step per sweep,
// derives each pair's window boundaries and expected error count arithmetically
// from the settle/measure lengths, and checks outputs against that timeline.

module tb_eq_sweep_ctrl;

    localparam int TW   = 32;
    localparam int TXW  = 4;
    localparam int RXW  = 4;
    localparam int TXM  = 1;
    localparam int RXM  = 1;
    localparam int FC   = 4;
    localparam int ST   = 100;
    localparam int MT   = 200;
    localparam int EW   = 4;
    localparam int NP   = (TXM + 1) * (RXM + 1);
    localparam int EMAX = (1 << EW) - 1;

    logic           clk_sys;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [TW-1:0]  time_curr;
    logic           err_valid;
    logic           err;
    logic [TXW-1:0] tx_setting;
    logic [RXW-1:0] rx_setting;
    logic           clk_en;
    logic           emu_rst_n;
    logic           busy;
    logic           done;
    logic [EW-1:0]  err_count;
    logic [TXW-1:0] best_tx;
    logic [RXW-1:0] best_rx;
    logic [EW-1:0]  best_err;

    eq_sweep_ctrl #(
        .TIME_WIDTH(TW), .TX_SETTING_WIDTH(TXW), .RX_SETTING_WIDTH(RXW),
        .TX_MAX(TXM), .RX_MAX(RXM), .FLUSH_CYCLES(FC),
        .SETTLE_TIME(ST), .MEASURE_TIME(MT), .ERR_WIDTH(EW)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .abort(abort),
        .time_curr(time_curr), .err_valid(err_valid), .err(err),
        .tx_setting(tx_setting), .rx_setting(rx_setting), .clk_en(clk_en),
        .emu_rst_n(emu_rst_n), .busy(busy), .done(done), .err_count(err_count),
        .best_tx(best_tx), .best_rx(best_rx), .best_err(best_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int total;
    int bad;
    int m_best_tx;
    int m_best_rx;
    int m_best_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".tx"},        tx_setting, 0);
        check_eq({tag, ".rx"},        rx_setting, 0);
        check_eq({tag, ".clk_en"},    clk_en,     0);
        check_eq({tag, ".emu_rst_n"}, emu_rst_n,  0);
        check_eq({tag, ".busy"},      busy,       0);
        check_eq({tag, ".done"},      done,       0);
        check_eq({tag, ".err_count"}, err_count,  0);
        check_eq({tag, ".best_tx"},   best_tx,    0);
        check_eq({tag, ".best_rx"},   best_rx,    0);
        check_eq({tag, ".best_err"},  best_err,   EMAX);
    endtask

    // One sweep started from IDLE/DONE. mode selects the error pattern;
    // abort_pair >= 0 aborts three cycles into that pair's measure window.
    task automatic run_sweep(input int step, input logic [31:0] base, input int mode,
                             input int abort_pair);
        bit evv [NP][200];
        bit erv [NP][200];
        int cnt [NP];
        int k, m, ms, me, plen, abort_at, last_c;
        int c4 [4] = '{5, 2, 2, 7};

        k    = (ST + step - 1) / step;
        m    = (MT + step - 1) / step;
        ms   = FC + 1 + k;
        me   = ms + m;
        plen = me + 3;
        abort_at = (abort_pair >= 0) ? (1 + abort_pair * plen + ms + 3) : -1;
        last_c   = NP * plen + 3;

        for (int p = 0; p < NP; p++) begin
            for (int o = 0; o < 200; o++) begin
                evv[p][o] = 1'b0;
                erv[p][o] = 1'b0;
            end
            case (mode)
                1: begin
                    for (int i = 0; i < c4[p % 4]; i++) begin
                        evv[p][ms + 2 + i] = 1'b1;
                        erv[p][ms + 2 + i] = 1'b1;
                    end
                    foreach (c4[j]) begin end
                    evv[p][1] = 1'b1;      erv[p][1] = 1'b1;
                    evv[p][4] = 1'b1;      erv[p][4] = 1'b1;
                    evv[p][ms] = 1'b1;     erv[p][ms] = 1'b1;
                    evv[p][me + 1] = 1'b1; erv[p][me + 1] = 1'b1;
                    evv[p][me + 2] = 1'b1; erv[p][me + 2] = 1'b1;
                    if (ms + 15 <= me) evv[p][ms + 15] = 1'b1;
                end
                2: begin
                    evv[p][1] = 1'b1;      erv[p][1] = 1'b1;
                    evv[p][4] = 1'b1;      erv[p][4] = 1'b1;
                    evv[p][ms] = 1'b1;     erv[p][ms] = 1'b1;
                    evv[p][me] = 1'b1;     erv[p][me] = 1'b1;
                    evv[p][me + 1] = 1'b1; erv[p][me + 1] = 1'b1;
                end
                3, 4: begin
                    for (int o = 0; o < plen; o++) begin
                        evv[p][o] = ($urandom_range(0, 2) == 0);
                        erv[p][o] = $urandom_range(0, 1) == 1;
                    end
                    if (mode == 3 && p == 0) begin
                        for (int o = ms + 1; o <= me; o++) begin
                            evv[p][o] = 1'b1;
                            erv[p][o] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            cnt[p] = 0;
            for (int o = ms + 1; o <= me; o++)
                if (evv[p][o] && erv[p][o]) cnt[p]++;
            if (cnt[p] > EMAX) cnt[p] = EMAX;
        end

        m_best_err = EMAX;
        start = 1'b1; abort = 1'b0; err_valid = 1'b0; err = 1'b0; time_curr = base;
        @(posedge clk_sys); #1;
        start = 1'b0;

        for (int c = 1; c <= last_c; c++) begin
            int p, o;
            p = (c - 1) / plen;
            o = (c - 1) % plen;
            time_curr = base + 32'(step * c);
            if (p < NP) begin
                err_valid = evv[p][o];
                err       = erv[p][o];
                start     = ($urandom_range(0, 7) == 0);
                abort     = (c == abort_at);
            end else begin
                err_valid = $urandom_range(0, 1) == 1;
                err       = 1'b1;
                start     = 1'b0;
                abort     = 1'b0;
            end
            @(negedge clk_sys);
            if (p < NP) begin
                check_eq("busy", busy, 1);
                check_eq("done", done, 0);
                check_eq("tx_setting", tx_setting, p / (RXM + 1));
                check_eq("rx_setting", rx_setting, p % (RXM + 1));
                check_eq("clk_en", clk_en, (o <= me) ? 1 : 0);
                if (o <= me) check_eq("emu_rst_n", emu_rst_n, (o >= FC) ? 1 : 0);
                if (p == 0 && o == 0) check_eq("best_err_cleared", best_err, EMAX);
                if (o == me + 1) begin
                    check_eq("err_count", err_count, cnt[p]);
                    if (cnt[p] < m_best_err) begin
                        m_best_err = cnt[p];
                        m_best_tx  = p / (RXM + 1);
                        m_best_rx  = p % (RXM + 1);
                    end
                end
                if (o == me + 2) begin
                    check_eq("best_tx", best_tx, m_best_tx);
                    check_eq("best_rx", best_rx, m_best_rx);
                    check_eq("best_err", best_err, m_best_err);
                end
            end else begin
                check_eq("done.busy", busy, 0);
                check_eq("done.done", done, 1);
                check_eq("done.clk_en", clk_en, 0);
                check_eq("done.emu_rst_n", emu_rst_n, 0);
                check_eq("done.tx", tx_setting, TXM);
                check_eq("done.rx", rx_setting, RXM);
                check_eq("done.err_count", err_count, cnt[NP - 1]);
                check_eq("done.best_tx", best_tx, m_best_tx);
                check_eq("done.best_rx", best_rx, m_best_rx);
                check_eq("done.best_err", best_err, m_best_err);
            end
            if (c == abort_at) begin
                @(posedge clk_sys); #1;
                abort = 1'b0; start = 1'b0; err_valid = 1'b0;
                @(negedge clk_sys);
                check_eq("abort.busy", busy, 0);
                check_eq("abort.done", done, 0);
                check_eq("abort.clk_en", clk_en, 0);
                check_eq("abort.emu_rst_n", emu_rst_n, 0);
                check_eq("abort.best_tx", best_tx, m_best_tx);
                check_eq("abort.best_rx", best_rx, m_best_rx);
                check_eq("abort.best_err", best_err, m_best_err);
                @(posedge clk_sys); #1;
                return;
            end
            @(posedge clk_sys); #1;
        end
        start = 1'b0; err_valid = 1'b0; err = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got busy=%0d expected finish", busy);
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        m_best_tx = 0; m_best_rx = 0; m_best_err = EMAX;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        time_curr = '0; err_valid = 1'b0; err = 1'b0;
        #12;
        check_reset_vals("reset");
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        @(posedge clk_sys); #1;

        // clean link: best stays at the first pair with zero errors
        run_sweep(10, 32'd0, 0, -1);
        // 5/2/2/7 errors plus strobes outside the window: tie keeps (0,1)
        run_sweep(10, 32'd1000, 1, -1);
        // settle window straddles the 32-bit wrap; entry/exit strobes
        run_sweep(10, 32'hFFFF_FF9C, 2, -1);
        // saturating window on the first pair
        run_sweep(10, 32'd5000, 3, -1);
        // abort during measure of pair (1,0)
        run_sweep(10, 32'd777, 4, 2);

        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk_sys);
        check_eq("start_abort.busy", busy, 0);
        check_eq("start_abort.clk_en", clk_en, 0);
        @(posedge clk_sys); #1;

        // restart after abort sweeps from (0,0)
        run_sweep(10, 32'd0, 4, -1);

        for (int s = 0; s < 6; s++) begin
            run_sweep($urandom_range(3, 40), $urandom, (s == 2) ? 2 : 4, -1);
        end

        // asynchronous reset in the middle of FLUSH
        start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
        @(posedge clk_sys); #1;
        #3;
        rst_n = 1'b0;
        #1;
        m_best_tx = 0; m_best_rx = 0; m_best_err = EMAX;
        check_reset_vals("async_rst");
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        @(negedge clk_sys);
        check_eq("post_rst.busy", busy, 0);
        check_eq("post_rst.clk_en", clk_en, 0);
        @(posedge clk_sys); #1;

        run_sweep(25, 32'd123, 4, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
